reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst  in  1  asynchronous active-high reset; rdy  in  1  global enable, all state frozen when low.
REQ-002 in_decode_ce  in  1  allocate one entry this cycle.
REQ-003 in_decode_dest_reg  in  REG_TAG_WIDTH(5)  destination architectural register, 0 = none.
REQ-004 in_decode_is_branch  in  1  entry is a branch.
REQ-005 out_decode_rob_tag  out  ROB_TAG_WIDTH(4)  tag the next allocation receives, never 0.
REQ-006 out_rob_full  out  1  no free entry.
REQ-007 in_cdb_valid / in_cdb_tag(4) / in_cdb_value(32) / in_cdb_misbranch(1) / in_cdb_target_pc(32)  in  completion broadcast.
REQ-008 in_query_tag1, in_query_tag2  in  4; out_query_ready1/2  out  1; out_query_value1/2  out  32  operand lookup by tag.
REQ-009 out_reg_commit_reg(5) / out_reg_commit_rob(4) / out_reg_commit_value(32)  out  commit write to register file.
REQ-010 out_rob_misbranch  out  1; out_misbranch_pc  out  32  flush request and redirect target.

Function
REQ-011 Circular buffer, tags 1..15, tag 0 = "no tag"; capacity 15; head/tail increment 15 -> 1, skipping 0.
REQ-012 out_decode_rob_tag = tail; out_rob_full = (count == 15), both combinational from registered state.
REQ-013 Allocation on in_decode_ce && !out_rob_full: entry busy, not ready, dest/is_branch stored, tail advances; in_decode_ce while full ignored.
REQ-014 CDB with in_cdb_valid to a busy entry sets ready, stores value, misbranch flag, target; to a non-busy tag ignored.
REQ-015 Commit at most one entry per cycle: when head entry busy and ready, next edge drives out_reg_commit_reg/rob/value from it, frees it, advances head.
REQ-016 Commit outputs registered; out_reg_commit_reg = 0, rob = 0, value = 0 in cycles without a commit.
REQ-017 Entry with dest_reg 0 commits with out_reg_commit_reg = 0.
REQ-018 Committing a branch with misbranch flag set: out_rob_misbranch = 1 and out_misbranch_pc = target for exactly one cycle; same edge clears all busy bits, head = tail = 1, count = 0.
REQ-019 Allocation in the flush cycle is discarded.
REQ-020 Simultaneous allocate and commit: both performed, count unchanged; allocation when full remains rejected even if a commit occurs that cycle.
REQ-021 Query: ready = entry busy && ready, value = entry value; tag 0 or non-busy tag returns ready 0, value 0.
REQ-022 rdy low: no allocation, completion, commit or flush; outputs hold.

Reset
REQ-023 rst asserted: all entries non-busy, head = tail = 1, count = 0, all commit outputs 0, out_rob_misbranch = 0, out_misbranch_pc = 0, regardless of clk or rdy.
REQ-024 Reset mid-operation discards all in-flight entries; no commit issued on the reset-release edge.

Configuration
REQ-025 Macro ROB_CDB_BYPASS_EN defined: query with in_cdb_valid and in_cdb_tag equal to queried busy tag returns ready 1 and in_cdb_value in the same cycle.
REQ-026 ROB_CDB_BYPASS_EN undefined: query reflects registered state only; result visible the cycle after broadcast.

Structure
REQ-027 DATA_WIDTH, REG_TAG_WIDTH, ROB_TAG_WIDTH, ROB_SIZE, ZERO_DATA, ZERO_TAG_ROB, TRUE/FALSE SHALL come from the shared constant include.
REQ-028 Single module; tag increment-with-wrap as one local function; no sub-modules.

Verification
REQ-029 Reset, allocate 3 entries (dest x1,x2,x3) -> tags 1,2,3; out_decode_rob_tag = 4.
REQ-030 CDB completes tag 2 (value 0x22) then tag 1 (0x11) -> commits x1=0x11 then x2=0x22 on consecutive cycles, tag 3 not committed.
REQ-031 Allocate 15 entries -> out_rob_full = 1; 16th in_decode_ce ignored; commit one, allocate -> tag wraps 15 -> 1.
REQ-032 Branch tag 4 completes with misbranch, target 0x100 -> one-cycle out_rob_misbranch = 1, out_misbranch_pc = 0x100; next cycle count 0, out_decode_rob_tag = 1.
REQ-033 Query tag 5 in the CDB cycle for tag 5, value 0xAB -> ready 1/0xAB with ROB_CDB_BYPASS_EN, ready 0 without, ready 1 next cycle both.
REQ-034 rdy low for 3 cycles with ready head -> no commit; commit occurs on first edge with rdy high.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer: data/tag widths, capacity,
// zero values and the registered commit record.
package reorder_buffer_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int REG_TAG_WIDTH = 5;
  localparam int ROB_TAG_WIDTH = 4;
  localparam int ROB_SIZE      = 15;

  localparam logic [DATA_WIDTH-1:0]    ZERO_DATA    = '0;
  localparam logic [ROB_TAG_WIDTH-1:0] ZERO_TAG_ROB = '0;
  localparam logic [REG_TAG_WIDTH-1:0] ZERO_TAG_REG = '0;
  localparam logic                     TRUE         = 1'b1;
  localparam logic                     FALSE        = 1'b0;

  typedef logic [DATA_WIDTH-1:0]    data_t;
  typedef logic [REG_TAG_WIDTH-1:0] reg_tag_t;
  typedef logic [ROB_TAG_WIDTH-1:0] rob_tag_t;

  typedef struct packed {
    reg_tag_t rd;
    rob_tag_t rob;
    data_t    value;
  } commit_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Decode, completion-broadcast, operand-query, commit and flush signals of the
// reorder buffer. The master modport is the surrounding pipeline, slave is the ROB.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic     in_decode_ce;
  reg_tag_t in_decode_dest_reg;
  logic     in_decode_is_branch;
  rob_tag_t out_decode_rob_tag;
  logic     out_rob_full;

  logic     in_cdb_valid;
  rob_tag_t in_cdb_tag;
  data_t    in_cdb_value;
  logic     in_cdb_misbranch;
  data_t    in_cdb_target_pc;

  rob_tag_t in_query_tag1;
  rob_tag_t in_query_tag2;
  logic     out_query_ready1;
  logic     out_query_ready2;
  data_t    out_query_value1;
  data_t    out_query_value2;

  reg_tag_t out_reg_commit_reg;
  rob_tag_t out_reg_commit_rob;
  data_t    out_reg_commit_value;

  logic     out_rob_misbranch;
  data_t    out_misbranch_pc;

  modport master (
    output in_decode_ce, in_decode_dest_reg, in_decode_is_branch,
    input  out_decode_rob_tag, out_rob_full,
    output in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_misbranch, in_cdb_target_pc,
    output in_query_tag1, in_query_tag2,
    input  out_query_ready1, out_query_ready2, out_query_value1, out_query_value2,
    input  out_reg_commit_reg, out_reg_commit_rob, out_reg_commit_value,
    input  out_rob_misbranch, out_misbranch_pc
  );

  modport slave (
    input  in_decode_ce, in_decode_dest_reg, in_decode_is_branch,
    output out_decode_rob_tag, out_rob_full,
    input  in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_misbranch, in_cdb_target_pc,
    input  in_query_tag1, in_query_tag2,
    output out_query_ready1, out_query_ready2, out_query_value1, out_query_value2,
    output out_reg_commit_reg, out_reg_commit_rob, out_reg_commit_value,
    output out_rob_misbranch, out_misbranch_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// 15-entry in-order-commit reorder buffer with tags 1..15 (0 means "no tag").
// Define ROB_CDB_BYPASS_EN to let operand queries see a same-cycle CDB broadcast.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  reorder_buffer_if.slave bus
);

  localparam int ENTRIES = ROB_SIZE + 1;

  function automatic rob_tag_t next_tag(input rob_tag_t tag);
    return (tag == rob_tag_t'(ROB_SIZE)) ? rob_tag_t'(1) : tag + rob_tag_t'(1);
  endfunction

  // Control state (reset)
  logic [ENTRIES-1:0] busy_q, busy_d;
  rob_tag_t           head_q, head_d;
  rob_tag_t           tail_q, tail_d;
  rob_tag_t           count_q, count_d;
  commit_t            commit_q, commit_d;
  logic               misbranch_q, misbranch_d;
  data_t              misbranch_pc_q, misbranch_pc_d;

  // Entry payload; only meaningful while the matching busy bit is set
  logic [ENTRIES-1:0] ready_q;
  logic [ENTRIES-1:0] is_branch_q;
  logic [ENTRIES-1:0] mispredict_q;
  reg_tag_t           dest_q   [ENTRIES];
  data_t              value_q  [ENTRIES];
  data_t              target_q [ENTRIES];

  logic full;
  logic alloc_en;
  logic cdb_hit;
  logic commit_en;
  logic flush_en;

  assign full      = (count_q == rob_tag_t'(ROB_SIZE));
  assign alloc_en  = rdy && bus.in_decode_ce && !full;
  assign cdb_hit   = rdy && bus.in_cdb_valid && (bus.in_cdb_tag != ZERO_TAG_ROB)
                     && busy_q[bus.in_cdb_tag];
  assign commit_en = rdy && busy_q[head_q] && ready_q[head_q];
  assign flush_en  = commit_en && is_branch_q[head_q] && mispredict_q[head_q];

  always_comb begin
    busy_d         = busy_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_d       = rdy ? '0 : commit_q;
    misbranch_d    = rdy ? FALSE : misbranch_q;
    misbranch_pc_d = rdy ? ZERO_DATA : misbranch_pc_q;

    if (commit_en) begin
      busy_d[head_q] = FALSE;
      head_d         = next_tag(head_q);
      commit_d.rd    = dest_q[head_q];
      commit_d.rob   = head_q;
      commit_d.value = value_q[head_q];
    end

    if (alloc_en) begin
      busy_d[tail_q] = TRUE;
      tail_d         = next_tag(tail_q);
    end

    case ({alloc_en, commit_en})
      2'b10:   count_d = count_q + rob_tag_t'(1);
      2'b01:   count_d = count_q - rob_tag_t'(1);
      default: count_d = count_q;
    endcase

    // A mispredicted branch retiring wipes everything younger, including this cycle's allocation
    if (flush_en) begin
      busy_d         = '0;
      head_d         = rob_tag_t'(1);
      tail_d         = rob_tag_t'(1);
      count_d        = ZERO_TAG_ROB;
      misbranch_d    = TRUE;
      misbranch_pc_d = target_q[head_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q         <= '0;
      head_q         <= rob_tag_t'(1);
      tail_q         <= rob_tag_t'(1);
      count_q        <= ZERO_TAG_ROB;
      commit_q       <= '0;
      misbranch_q    <= FALSE;
      misbranch_pc_q <= ZERO_DATA;
    end else begin
      busy_q         <= busy_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_q       <= commit_d;
      misbranch_q    <= misbranch_d;
      misbranch_pc_q <= misbranch_pc_d;
    end
  end

  // Allocation targets a free slot and completion a busy one, so they never collide
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      ready_q[tail_q]      <= FALSE;
      is_branch_q[tail_q]  <= bus.in_decode_is_branch;
      mispredict_q[tail_q] <= FALSE;
      dest_q[tail_q]       <= bus.in_decode_dest_reg;
    end
    if (cdb_hit) begin
      ready_q[bus.in_cdb_tag]      <= TRUE;
      mispredict_q[bus.in_cdb_tag] <= bus.in_cdb_misbranch;
      value_q[bus.in_cdb_tag]      <= bus.in_cdb_value;
      target_q[bus.in_cdb_tag]     <= bus.in_cdb_target_pc;
    end
  end

  logic  q_rdy1, q_rdy2;
  data_t q_val1, q_val2;

  always_comb begin
    q_rdy1 = (bus.in_query_tag1 != ZERO_TAG_ROB) && busy_q[bus.in_query_tag1]
             && ready_q[bus.in_query_tag1];
    q_val1 = q_rdy1 ? value_q[bus.in_query_tag1] : ZERO_DATA;
    q_rdy2 = (bus.in_query_tag2 != ZERO_TAG_ROB) && busy_q[bus.in_query_tag2]
             && ready_q[bus.in_query_tag2];
    q_val2 = q_rdy2 ? value_q[bus.in_query_tag2] : ZERO_DATA;
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_hit && (bus.in_cdb_tag == bus.in_query_tag1)) begin
      q_rdy1 = TRUE;
      q_val1 = bus.in_cdb_value;
    end
    if (cdb_hit && (bus.in_cdb_tag == bus.in_query_tag2)) begin
      q_rdy2 = TRUE;
      q_val2 = bus.in_cdb_value;
    end
`endif
  end

  assign bus.out_decode_rob_tag   = tail_q;
  assign bus.out_rob_full         = full;
  assign bus.out_query_ready1     = q_rdy1;
  assign bus.out_query_ready2     = q_rdy2;
  assign bus.out_query_value1     = q_val1;
  assign bus.out_query_value2     = q_val2;
  assign bus.out_reg_commit_reg   = commit_q.rd;
  assign bus.out_reg_commit_rob   = commit_q.rob;
  assign bus.out_reg_commit_value = commit_q.value;
  assign bus.out_rob_misbranch    = misbranch_q;
  assign bus.out_misbranch_pc     = misbranch_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed test of reorder_buffer: allocation, in-order commit, wrap, flush,
// query bypass, rdy stall and mid-run reset, against hand-computed values.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  reorder_buffer_if bus();

  reorder_buffer dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_byp_rdy;
  logic [31:0] exp_byp_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-16s got 0x%0h ok", tag, obs);
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_decode_ce        = 1'b0;
    bus.in_decode_dest_reg  = '0;
    bus.in_decode_is_branch = 1'b0;
    bus.in_cdb_valid        = 1'b0;
    bus.in_cdb_tag          = '0;
    bus.in_cdb_value        = '0;
    bus.in_cdb_misbranch    = 1'b0;
    bus.in_cdb_target_pc    = '0;
    bus.in_query_tag1       = '0;
    bus.in_query_tag2       = '0;
  endtask

  task automatic cdb(input int tag, input logic [31:0] value, input logic misb,
                     input logic [31:0] target);
    bus.in_cdb_valid     = 1'b1;
    bus.in_cdb_tag       = rob_tag_t'(tag);
    bus.in_cdb_value     = value;
    bus.in_cdb_misbranch = misb;
    bus.in_cdb_target_pc = target;
  endtask

  task automatic check_commit(input string tag, input int rd, input int rob,
                              input logic [31:0] value);
    check({tag, ".reg"}, 32'(bus.out_reg_commit_reg), 32'(rd));
    check({tag, ".rob"}, 32'(bus.out_reg_commit_rob), 32'(rob));
    check({tag, ".val"}, bus.out_reg_commit_value, value);
  endtask

  initial begin
`ifdef ROB_CDB_BYPASS_EN
    exp_byp_rdy = 32'd1;
    exp_byp_val = 32'hAB;
`else
    exp_byp_rdy = 32'd0;
    exp_byp_val = 32'h0;
`endif
    rst = 1'b1;
    rdy = 1'b1;
    idle_inputs();
    step();
    step();
    check("rst_tag", 32'(bus.out_decode_rob_tag), 32'd1);
    check("rst_full", 32'(bus.out_rob_full), 32'd0);
    check_commit("rst_commit", 0, 0, 32'h0);
    check("rst_misb", 32'(bus.out_rob_misbranch), 32'd0);
    check("rst_pc", bus.out_misbranch_pc, 32'h0);
    rst = 1'b0;

    // Three allocations x1..x3
    for (int i = 1; i <= 3; i++) begin
      check("alloc_tag", 32'(bus.out_decode_rob_tag), 32'(i));
      bus.in_decode_ce       = 1'b1;
      bus.in_decode_dest_reg = reg_tag_t'(i);
      step();
    end
    idle_inputs();
    check("tag_after3", 32'(bus.out_decode_rob_tag), 32'd4);

    // Out-of-order completion, in-order commit
    cdb(2, 32'h22, 1'b0, 32'h0);
    step();
    idle_inputs();
    bus.in_query_tag1 = 4'd2;
    bus.in_query_tag2 = 4'd3;
    #1;
    check("q_t2_rdy", 32'(bus.out_query_ready1), 32'd1);
    check("q_t2_val", bus.out_query_value1, 32'h22);
    check("q_t3_rdy", 32'(bus.out_query_ready2), 32'd0);
    check("q_t3_val", bus.out_query_value2, 32'h0);
    cdb(1, 32'h11, 1'b0, 32'h0);
    step();
    idle_inputs();
    check_commit("no_commit", 0, 0, 32'h0);
    step();
    check_commit("commit_x1", 1, 1, 32'h11);
    step();
    check_commit("commit_x2", 2, 2, 32'h22);
    step();
    check_commit("hold_t3", 0, 0, 32'h0);

    // Branch at tag 4 mispredicts; tag 5 and the flush-cycle allocation are dropped
    bus.in_decode_ce        = 1'b1;
    bus.in_decode_dest_reg  = 5'd0;
    bus.in_decode_is_branch = 1'b1;
    step();
    bus.in_decode_dest_reg  = 5'd5;
    bus.in_decode_is_branch = 1'b0;
    cdb(3, 32'h33, 1'b0, 32'h0);
    step();
    idle_inputs();
    cdb(4, 32'h44, 1'b1, 32'h100);
    step();
    idle_inputs();
    check_commit("commit_x3", 3, 3, 32'h33);
    check("misb_pre", 32'(bus.out_rob_misbranch), 32'd0);
    bus.in_decode_ce       = 1'b1;
    bus.in_decode_dest_reg = 5'd7;
    step();
    idle_inputs();
    check_commit("commit_br", 0, 4, 32'h44);
    check("misb_flag", 32'(bus.out_rob_misbranch), 32'd1);
    check("misb_pc", bus.out_misbranch_pc, 32'h100);
    check("flush_tag", 32'(bus.out_decode_rob_tag), 32'd1);
    check("flush_full", 32'(bus.out_rob_full), 32'd0);
    step();
    check("misb_clear", 32'(bus.out_rob_misbranch), 32'd0);
    check("misb_pc_clr", bus.out_misbranch_pc, 32'h0);
    check_commit("post_flush", 0, 0, 32'h0);
    check("post_fl_tag", 32'(bus.out_decode_rob_tag), 32'd1);
    bus.in_query_tag1 = 4'd5;
    #1;
    check("q_flushed", 32'(bus.out_query_ready1), 32'd0);
    idle_inputs();

    // Allocate tags 1..5, then query tag 5 while it is being broadcast
    for (int i = 1; i <= 5; i++) begin
      bus.in_decode_ce       = 1'b1;
      bus.in_decode_dest_reg = reg_tag_t'(i);
      step();
    end
    idle_inputs();
    cdb(5, 32'hAB, 1'b0, 32'h0);
    bus.in_query_tag1 = 4'd5;
    bus.in_query_tag2 = 4'd0;
    #1;
    check("byp_rdy", 32'(bus.out_query_ready1), exp_byp_rdy);
    check("byp_val", bus.out_query_value1, exp_byp_val);
    check("q_tag0_rdy", 32'(bus.out_query_ready2), 32'd0);
    check("q_tag0_val", bus.out_query_value2, 32'h0);
    step();
    bus.in_cdb_valid = 1'b0;
    #1;
    check("q5_next_rdy", 32'(bus.out_query_ready1), 32'd1);
    check("q5_next_val", bus.out_query_value1, 32'hAB);
    idle_inputs();

    // Fill to 15, reject extra allocations, wrap tail 15 -> 1
    for (int i = 6; i <= 15; i++) begin
      check("fill_tag", 32'(bus.out_decode_rob_tag), 32'(i));
      bus.in_decode_ce       = 1'b1;
      bus.in_decode_dest_reg = reg_tag_t'(i);
      step();
    end
    idle_inputs();
    check("full", 32'(bus.out_rob_full), 32'd1);
    check("full_tag", 32'(bus.out_decode_rob_tag), 32'd1);
    bus.in_decode_ce = 1'b1;
    step();
    idle_inputs();
    check("full_reject", 32'(bus.out_rob_full), 32'd1);
    check("rej_tag", 32'(bus.out_decode_rob_tag), 32'd1);
    cdb(1, 32'h5A, 1'b0, 32'h0);
    step();
    idle_inputs();
    bus.in_decode_ce       = 1'b1;
    bus.in_decode_dest_reg = 5'd12;
    step();
    check_commit("commit_full", 1, 1, 32'h5A);
    check("full_after_c", 32'(bus.out_rob_full), 32'd0);
    check("tag_no_alloc", 32'(bus.out_decode_rob_tag), 32'd1);
    step();
    idle_inputs();
    check("wrap_full", 32'(bus.out_rob_full), 32'd1);
    check("wrap_tag", 32'(bus.out_decode_rob_tag), 32'd2);
    check_commit("wrap_nocommit", 0, 0, 32'h0);

    // rdy low stalls a ready head; commit happens on the first rdy-high edge
    cdb(2, 32'h77, 1'b0, 32'h0);
    step();
    idle_inputs();
    check_commit("pre_stall", 0, 0, 32'h0);
    rdy = 1'b0;
    bus.in_decode_ce = 1'b1;
    cdb(3, 32'h99, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rob", 32'(bus.out_reg_commit_rob), 32'd0);
      check("stall_full", 32'(bus.out_rob_full), 32'd1);
    end
    rdy = 1'b1;
    idle_inputs();
    step();
    check_commit("stall_commit", 2, 2, 32'h77);
    check("stall_tag", 32'(bus.out_decode_rob_tag), 32'd2);
    bus.in_query_tag1 = 4'd3;
    #1;
    check("q_t3_frozen", 32'(bus.out_query_ready1), 32'd0);

    // Asynchronous reset mid-operation
    rst = 1'b1;
    #1;
    check("arst_tag", 32'(bus.out_decode_rob_tag), 32'd1);
    check("arst_full", 32'(bus.out_rob_full), 32'd0);
    check_commit("arst_commit", 0, 0, 32'h0);
    step();
    rst = 1'b0;
    step();
    check_commit("post_rst", 0, 0, 32'h0);
    check("post_rst_tag", 32'(bus.out_decode_rob_tag), 32'd1);
    bus.in_query_tag1 = 4'd4;
    #1;
    check("post_rst_q", 32'(bus.out_query_ready1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
